// File: rtl/shift_cmd_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_cmd_queue                                                          |
// | Command FIFO in front of a combinational left shifter, with a registered |
// | valid/ready result stage. Optional macro: SHIFT_CMD_QUEUE_LOSS_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shift_cmd_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_bits,
    input  logic [$clog2(WIDTH)-1:0] in_shift,
    output logic [WIDTH-1:0]         sh_bits,
    output logic [$clog2(WIDTH)-1:0] sh_shift,
    input  logic [WIDTH-1:0]         sh_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_bits,
`ifdef SHIFT_CMD_QUEUE_LOSS_EN
    output logic                     out_loss,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_sw = $clog2(WIDTH);
    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full    = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw-1:0] c_ptr_one = 1;
    localparam logic [c_aw:0]   c_cnt_one = 1;

    logic [WIDTH-1:0] r_mem_bits  [DEPTH];
    logic [c_sw-1:0]  r_mem_shift [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_bits;
    logic             w_empty;
    logic             w_push;
    logic             w_load;

    // A full queue refuses input even if the head pops this cycle.
    assign w_empty   = (r_count == '0);
    assign in_ready  = (r_count != c_full);
    assign w_push    = in_valid && in_ready;
    assign w_load    = !w_empty && (!r_out_valid || out_ready);

    assign sh_bits   = w_empty ? '0 : r_mem_bits[r_rd_ptr];
    assign sh_shift  = w_empty ? '0 : r_mem_shift[r_rd_ptr];
    assign out_valid = r_out_valid;
    assign out_bits  = r_out_bits;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_bits[r_wr_ptr]  <= in_bits;
            r_mem_shift[r_wr_ptr] <= in_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_load) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Loading always wins over draining; a consumed result with nothing
    // behind it simply clears valid and leaves the data in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_bits  <= sh_result;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef SHIFT_CMD_QUEUE_LOSS_EN
    logic [31:0] w_top_shamt;
    logic        w_loss;
    logic        r_out_loss;

    assign w_top_shamt = 32'(WIDTH) - 32'(sh_shift);
    assign w_loss      = (sh_shift != '0) && ((sh_bits >> w_top_shamt) != '0);
    assign out_loss    = r_out_loss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_loss <= 1'b0;
        end else if (w_load) begin
            r_out_loss <= w_loss;
        end
    end
`endif

endmodule
`default_nettype wire
